// File: rtl/bm_pkg.sv
// Shared definitions for the Box-Muller stream controller.
// Provides the controller FSM state type, the {s1,s2} product pair layout
// and default sizing constants used by bm_stream_ctrl and its pair FIFO.
package bm_pkg;

  // Default datapath sample width (the datapath also exists in a 48-bit flavour)
  localparam int BM_OUT_W    = 32;
  // Default cycles from gen_en to a valid product on bm_out1/bm_out2
  localparam int BM_PIPE_LAT = 4;
  // Default pair-FIFO depth in pairs (power of 2)
  localparam int BM_DEPTH    = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } bm_state_t;

  // One captured product pair: s1 = sin product (sent first), s2 = cos product
  typedef struct packed {
    logic [BM_OUT_W-1:0] s1;
    logic [BM_OUT_W-1:0] s2;
  } bm_pair_t;

endpackage

// File: rtl/bm_pair_fifo.sv
// Small synchronous FIFO holding captured product pairs.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push/data   write one entry (ignored when full)
//   pop         retire the head entry (ignored when empty)
//   head        current head entry, valid whenever empty=0
//   full/empty  occupancy flags derived from the registered count
//   count       registered number of stored entries, 0..DEPTH
// The head is read combinationally so the serialiser can present a pair in
// the cycle right after it is captured; with a handful of entries this maps
// to distributed storage rather than block RAM.
module bm_pair_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage is not reset; stale contents are never visible because the
  // consumer gates everything with empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bm_stream_ctrl.sv
// Sequencing controller for the Box-Muller Gaussian datapath.
// Issues datapath enables under a credit limit, tracks in-flight pairs with a
// tag shift register matching the datapath latency, captures each
// {bm_out1,bm_out2} pair into a pair FIFO and serialises the pairs onto a
// single valid/ready sample stream (out1 half first, then out2 half).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, burst_len    begin a burst of burst_len samples (0 = continuous)
//   stop                end continuous mode
//   gen_en              datapath advance/read enable
//   bm_out1, bm_out2    datapath sin / cos products
//   s_data, s_valid     output sample stream
//   s_ready             consumer ready
//   busy                controller not idle
//   done                one-cycle pulse when the burst has fully drained
module bm_stream_ctrl
  import bm_pkg::*;
#(
  parameter int OUT      = 32,
  parameter int PIPE_LAT = BM_PIPE_LAT,
  parameter int DEPTH    = BM_DEPTH,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             stop,
  output logic             gen_en,
  input  logic [OUT-1:0]   bm_out1,
  input  logic [OUT-1:0]   bm_out2,
  output logic [OUT-1:0]   s_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(PIPE_LAT+1);
  localparam int FW = $clog2(DEPTH+1);

  bm_state_t        state_reg;
  bm_state_t        state_next;
  logic             cont_reg;
  logic [CNT_W-1:0] pairs_left_reg;
  logic [CNT_W-1:0] samples_left_reg;
  logic             half_reg;
  logic [PIPE_LAT-1:0] tag_reg;
  logic [PIPE_LAT-1:0] tag_next;
  logic [IW-1:0]    inflight_reg;

  logic [2*OUT-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_count;

  logic             capture;
  logic             credits_ok;
  logic             hs;
  logic             last_odd;
  logic             pop;
  logic             drained;
  logic             accept;
  logic [CNT_W-1:0] pairs_init;

  // ceil(burst_len/2) without needing an extra carry bit
  assign pairs_init = (burst_len >> 1) + {{(CNT_W-1){1'b0}}, burst_len[0]};
  assign accept     = (state_reg == IDLE) && start;
  assign busy       = (state_reg != IDLE);

  // A tag leaving the last stage means the datapath presents its product now
  assign capture    = tag_reg[PIPE_LAT-1];
  // Every issued pair owns a FIFO slot from issue until it is popped, so the
  // FIFO can never overflow at capture time.
  assign credits_ok = (32'(inflight_reg) + 32'(fifo_count)) < 32'(DEPTH);

  assign s_valid  = !fifo_empty;
  assign hs       = s_valid && s_ready;
  // Only the final pair of an odd finite burst is reached with one sample left
  // while its out1 half is still pending; its out2 half is dropped.
  assign last_odd = !cont_reg && (samples_left_reg == CNT_W'(1));
  assign pop      = hs && (half_reg || last_odd);
  assign s_data   = !s_valid ? '0
                  : (half_reg ? fifo_head[OUT-1:0] : fifo_head[2*OUT-1:OUT]);
  assign drained  = (inflight_reg == '0) && fifo_empty && !half_reg;

  // Tag shift register: stage 0 takes gen_en, each later stage its predecessor
  assign tag_next[0] = gen_en;
  generate
    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_tag
      assign tag_next[gi] = tag_reg[gi-1];
    end
  endgenerate

  bm_pair_fifo #(
    .W     (2*OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture && !fifo_full),
    .push_data ({bm_out1, bm_out2}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state and FSM outputs
  always_comb begin
    state_next = state_reg;
    gen_en     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cont_reg) begin
          // stop suppresses issue in the same cycle it is seen
          if (stop) begin
            state_next = DRAIN;
          end else begin
            gen_en = credits_ok;
          end
        end else begin
          gen_en = credits_ok && (pairs_left_reg != '0);
          if ((pairs_left_reg == '0) ||
              (gen_en && (pairs_left_reg == CNT_W'(1)))) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cont_reg         <= 1'b0;
      pairs_left_reg   <= '0;
      samples_left_reg <= '0;
      half_reg         <= 1'b0;
      tag_reg          <= '0;
      inflight_reg     <= '0;
    end else begin
      state_reg <= state_next;
      tag_reg   <= tag_next;

      if (accept) begin
        cont_reg         <= (burst_len == '0);
        pairs_left_reg   <= pairs_init;
        samples_left_reg <= burst_len;
      end else begin
        if (gen_en && !cont_reg) begin
          pairs_left_reg <= pairs_left_reg - CNT_W'(1);
        end
        if (hs && !cont_reg) begin
          samples_left_reg <= samples_left_reg - CNT_W'(1);
        end
      end

      if (hs) begin
        half_reg <= !half_reg && !last_odd;
      end

      case ({gen_en, capture})
        2'b10:   inflight_reg <= inflight_reg + IW'(1);
        2'b01:   inflight_reg <= inflight_reg - IW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_bm_stream_ctrl.sv
// Self-checking bench for bm_stream_ctrl. A behavioural datapath model turns
// every gen_en cycle into a numbered token pair that appears PIPE_LAT cycles
// later; the expected sample stream is simply token 0 out1, token 0 out2,
// token 1 out1, ... truncated to the burst length.
module tb_bm_stream_ctrl;

  localparam int OUT      = 32;
  localparam int PIPE_LAT = 4;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic             stop;
  logic             gen_en;
  logic [OUT-1:0]   bm_out1;
  logic [OUT-1:0]   bm_out2;
  logic [OUT-1:0]   s_data;
  logic             s_valid;
  logic             s_ready;
  logic             busy;
  logic             done;

  bm_stream_ctrl #(
    .OUT      (OUT),
    .PIPE_LAT (PIPE_LAT),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .stop      (stop),
    .gen_en    (gen_en),
    .bm_out1   (bm_out1),
    .bm_out2   (bm_out2),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int next_seq = 0;
  bit dp_cycle_mode = 1'b0;
  int emerge_q[$];
  int seq_q[$];

  logic        gen_s   = 1'b0;
  logic        valid_s = 1'b0;
  logic        done_s  = 1'b0;
  logic        busy_s  = 1'b0;
  logic [31:0] data_s  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sample(input int i);
    return (((i % 2) == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(i / 2);
  endfunction

  // Datapath model: present a token when an earlier gen_en matures
  task automatic drive_dp();
    bit tok = 1'b0;
    int s = 0;
    if (emerge_q.size() > 0 && emerge_q[0] == cyc) begin
      tok = 1'b1;
      s = seq_q[0];
      void'(emerge_q.pop_front());
      void'(seq_q.pop_front());
    end
    if (dp_cycle_mode) begin
      bm_out1 = 32'(cyc);
      bm_out2 = ~32'(cyc);
    end else if (tok) begin
      bm_out1 = 32'hA000_0000 | 32'(s);
      bm_out2 = 32'hB000_0000 | 32'(s);
    end else begin
      bm_out1 = $urandom & 32'h0FFF_FFFF;
      bm_out2 = $urandom & 32'h0FFF_FFFF;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    gen_s   = gen_en;
    valid_s = s_valid;
    data_s  = s_data;
    done_s  = done;
    busy_s  = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (gen_s) begin
      emerge_q.push_back(cyc - 1 + PIPE_LAT);
      seq_q.push_back(next_seq);
      next_seq++;
    end
    drive_dp();
  endtask

  // One burst with randomized readiness, checked against the token model
  task automatic run_burst(input string tag, input int len, input int hold_low,
                           input int ready_pct, input int stop_at, input int restart_at);
    logic [31:0] got[$];
    int   gen_cnt = 0;
    int   gen_in_hold = 0;
    int   exp_n;
    int   n;
    bit   seen_done = 1'b0;
    bit   prev_hs = 1'b0;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    dp_cycle_mode = 1'b0;
    next_seq = 0;
    start = 1'b1;
    burst_len = CNT_W'(len);
    s_ready = 1'b0;
    stop = 1'b0;
    sample();
    chk({tag, " busy_at_start"}, busy_s, 0);
    tick();
    start = 1'b0;
    for (int k = 1; k < 3000 && !seen_done; k++) begin
      s_ready = (k <= hold_low) ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
      stop = (k == stop_at);
      if (k == restart_at) begin
        start = 1'b1;
        burst_len = CNT_W'(len + 7);
      end
      sample();
      if (stop) chk({tag, " gen_en_at_stop"}, gen_s, 0);
      if (prev_stall) begin
        chk({tag, " valid_held"}, valid_s, 1);
        chk({tag, " data_held"}, data_s, prev_data);
      end
      if (done_s) begin
        seen_done = 1'b1;
        chk({tag, " done_after_last_hs"}, prev_hs, 1);
      end
      if (gen_s) gen_cnt++;
      if (gen_s && k <= hold_low) gen_in_hold++;
      prev_hs = valid_s && s_ready;
      if (prev_hs) got.push_back(data_s);
      prev_stall = valid_s && !s_ready;
      prev_data = data_s;
      tick();
      start = 1'b0;
      stop = 1'b0;
    end
    chk({tag, " done_seen"}, seen_done, 1);
    exp_n = (len == 0) ? 2 * gen_cnt : len;
    if (len != 0) chk({tag, " gen_count"}, gen_cnt, (len + 1) / 2);
    if (hold_low > 0) chk({tag, " gen_during_hold"}, gen_in_hold, DEPTH);
    chk({tag, " sample_count"}, got.size(), exp_n);
    n = (got.size() < exp_n) ? got.size() : exp_n;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s sample%0d", tag, i), got[i], exp_sample(i));
    end
    $display("burst %s len=%0d: %0d samples, %0d gen cycles", tag, len, got.size(), gen_cnt);
    sample();
    chk({tag, " idle_after_done"}, busy_s, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    s_ready = 1'b0;
    burst_len = '0;
    bm_out1 = '0;
    bm_out2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset gen_en", gen_en, 0);
    chk("reset s_valid", s_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset s_data", s_data, 0);
    #2 rst = 1'b0;
    tick();

    // Burst of 4, always ready, datapath driven with the cycle index
    dp_cycle_mode = 1'b1;
    s_ready = 1'b1;
    start = 1'b1;
    burst_len = 16'd4;
    c0 = cyc;
    sample();
    chk("b4 c0 busy", busy_s, 0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      logic [31:0] ed;
      sample();
      chk($sformatf("b4 c%0d gen_en", c), gen_s, (c == 1 || c == 2) ? 1 : 0);
      chk($sformatf("b4 c%0d s_valid", c), valid_s, (c >= 6 && c <= 9) ? 1 : 0);
      chk($sformatf("b4 c%0d done", c), done_s, (c == 10) ? 1 : 0);
      chk($sformatf("b4 c%0d busy", c), busy_s, (c >= 1 && c <= 10) ? 1 : 0);
      if (c >= 6 && c <= 9) begin
        case (c)
          6:       ed = 32'(c0 + 5);
          7:       ed = ~32'(c0 + 5);
          8:       ed = 32'(c0 + 6);
          default: ed = ~32'(c0 + 6);
        endcase
        chk($sformatf("b4 c%0d s_data", c), data_s, ed);
      end
      $display("b4 cycle %0d: gen_en=%0b s_valid=%0b s_data=%08h done=%0b", c, gen_s, valid_s, data_s, done_s);
      tick();
    end
    dp_cycle_mode = 1'b0;

    run_burst("odd3", 3, 0, 100, 0, 0);
    run_burst("bp20", 20, 30, 70, 0, 0);
    run_burst("cont", 0, 0, 50, 40, 0);
    run_burst("restart", 10, 0, 80, 0, 2);
    for (int r = 0; r < 4; r++) begin
      run_burst($sformatf("rand%0d", r), int'($urandom_range(1, 15)), 0, 60, 0, 0);
    end

    // Asynchronous reset in the middle of a burst
    next_seq = 0;
    s_ready = 1'b1;
    start = 1'b1;
    burst_len = 16'd20;
    sample();
    tick();
    start = 1'b0;
    repeat (7) begin
      sample();
      tick();
    end
    sample();
    chk("midrst pre busy", busy_s, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst gen_en", gen_en, 0);
    chk("midrst s_valid", s_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst s_data", s_data, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst held done", done, 0);
    #2 rst = 1'b0;
    gen_s = 1'b0;
    emerge_q.delete();
    seq_q.delete();
    tick();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("postrst done", done_s, 0);
      chk("postrst busy", busy_s, 0);
      tick();
    end
    $display("mid-burst reset applied and released");
    run_burst("after_rst", 5, 0, 75, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bm_stream_ctrl.md
Name: bm_stream_ctrl

Overview:
- Sequencing controller for the Box-Muller Gaussian datapath: Tausworthe pair, sqrt/log ROM, sin/cos ROMs and two multipliers.
- Issues generator enables, tracks in-flight pairs through the fixed-latency pipeline and captures each {out1,out2} product pair into a small pair FIFO.
- Serialises the buffered pairs onto one valid/ready sample stream, with credit-based backpressure so no product is ever lost.
- Supports finite bursts of N samples and continuous mode with stop.

Parameters:
- OUT, 32: sample width; matches datapath output width (32 or 48).
- PIPE_LAT, 4: cycles from gen_en high to a valid product on bm_out1/bm_out2; must be ≥1.
- DEPTH, 4: pair-FIFO depth in pairs; power of 2, ≥2.
- CNT_W, 16: width of the burst length and sample counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- burst_len  in  CNT_W  sample count, latched on an accepted start; 0 selects continuous mode.
- stop  in  1  ends continuous mode; ignored in finite bursts.
- gen_en  out  1  datapath advance/read enable (drives re_s/re_lr gating).
- bm_out1  in  OUT  datapath sin product.
- bm_out2  in  OUT  datapath cos product.
- s_data  out  OUT  output sample.
- s_valid  out  1  s_data valid.
- s_ready  in  1  consumer ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; the burst or drain is complete.

Behaviour:
- Reset (async, any state):
  - FSM to IDLE; FIFO and in-flight tags cleared; counters 0.
  - gen_en, s_valid, busy, done and s_data all 0.
  - A reset mid-burst discards all buffered and in-flight data; no done pulse.
- FSM IDLE:
  - start=1 → latch burst_len into len_q.
  - Set pairs_left = ceil(len_q/2); len_q=0 marks continuous.
  - Go to RUN.
- FSM RUN, issue rule:
  - gen_en=1 iff credits_ok and (continuous or pairs_left>0).
  - credits_ok means inflight + fifo_count < DEPTH.
  - Each gen_en cycle decrements pairs_left (finite) and pushes a 1 into the PIPE_LAT-deep tag shift register.
- FSM RUN, exits:
  - Finite burst: pairs_left reaches 0 → DRAIN.
  - Continuous mode: stop=1 → DRAIN. gen_en is 0 in that same cycle.
- FSM DRAIN:
  - gen_en=0.
  - Wait until inflight=0, FIFO empty and the serialiser is idle.
  - Then pulse done for 1 cycle and return to IDLE.
- start outside IDLE: ignored. burst_len changes after acceptance: no effect.
- Capture: when a tag exits the shift register, write {bm_out1,bm_out2} into the FIFO in that cycle. The credit rule guarantees the FIFO never overflows.
- Serialiser:
  - s_valid=1 whenever the head pair holds an unsent half.
  - Order: bm_out1 half first, then bm_out2 half.
  - Advance only on s_valid&&s_ready; pop the pair after its last emitted half.
  - s_data is stable while s_valid=1 and s_ready=0.
- Odd finite len_q: the out2 half of the final pair is dropped, never presented. That pair pops after its out1 half.
- done coincides with the cycle after the last handshake. Samples emitted equal len_q exactly.
- Simultaneous capture and pop in the same cycle: fifo_count is unchanged, and the credit computation uses registered counts.
- Latency, start accepted at cycle 0:
  - gen_en first high at cycle 1.
  - Capture at the end of cycle 1+PIPE_LAT.
  - s_valid first high at cycle 2+PIPE_LAT.
- Counter widths: inflight holds 0..PIPE_LAT; fifo_count holds 0..DEPTH; sample counter is CNT_W, with no wrap in finite mode.

Decomposition:
- Shared package bm_pkg:
  - FSM state enum: IDLE, RUN, DRAIN.
  - Pair struct {s1,s2} of width OUT.
  - Default constants PIPE_LAT and DEPTH.
- One natural sub-module: bm_pair_fifo, a synchronous FIFO with registered count, push/pop, full/empty, and async active-high reset.

Test Plan:
- Burst, burst_len=4, s_ready=1, bm_out driven with the cycle index:
  - gen_en high on cycles 1–2.
  - s_valid from cycle 6: samples p0.out1, p0.out2, p1.out1, p1.out2.
  - done at cycle 10; busy low after.
- Odd burst, burst_len=3: exactly 3 handshakes, p1.out2 never appears, done follows the third handshake.
- Backpressure, burst_len=20 with s_ready=0 held for 30 cycles:
  - At most DEPTH gen_en cycles issued; gen_en stays 0 afterwards; s_data stable.
  - Release s_ready: all 20 samples arrive in order, none lost or duplicated.
- Continuous mode, burst_len=0, random s_ready:
  - Stream runs; stop at cycle 40 causes gen_en=0 the same cycle.
  - Every captured pair is emitted (both halves), then done.
- start pulsed during RUN with a different burst_len: ignored; the original count is completed.
- rst asserted mid-burst, asynchronous to clk edge:
  - All outputs are 0 immediately and there is no done pulse.
  - A new start then behaves as from power-up.
